// File: rtl/alu_seq_pkg.sv
// Shared opcode map and FSM state encodings for the sequential ALU.
// Decode imports the same opcode constants.
package alu_seq_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;
   localparam logic [2:0] OP_ILL = 3'b111;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Divide-by-zero short-circuits to a single-cycle error result.
   function automatic logic needs_iter(input logic [2:0] op, input logic op2_nz);
      return (op == OP_MUL) || ((op == OP_DIV) && op2_nz);
   endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative datapath: LSB-first shift-add multiply and restoring divide,
// one iteration per clock, WIDTH iterations per operation.
module alu_seq_muldiv
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op_is_div,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   output logic             done,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   // acc holds the high product / partial remainder, q the low product / quotient.
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] b_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             div_q;

   logic [WIDTH:0]   msum;
   logic [WIDTH:0]   rsh;
   logic             fits;

   always_comb begin
      msum  = {1'b0, acc_q} + (q_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
      rsh   = {acc_q, q_q[WIDTH-1]};
      fits  = (rsh >= {1'b0, b_q});
      cnt_d = cnt_q - CNT_W'(1);
      if (div_q) begin
         // Partial remainder stays below the divisor, so the low WIDTH bits suffice.
         acc_d = fits ? (rsh[WIDTH-1:0] - b_q) : rsh[WIDTH-1:0];
         q_d   = {q_q[WIDTH-2:0], fits};
      end else begin
         acc_d = msum[WIDTH:1];
         q_d   = {msum[0], q_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         q_q   <= '0;
         b_q   <= '0;
         cnt_q <= '0;
         div_q <= 1'b0;
      end else if (start) begin
         acc_q <= '0;
         q_q   <= op1;
         b_q   <= op2;
         cnt_q <= CNT_W'(WIDTH);
         div_q <= op_is_div;
      end else if (cnt_q != '0) begin
         acc_q <= acc_d;
         q_q   <= q_d;
         cnt_q <= cnt_d;
      end
   end

   // Outputs are the post-iteration values, so the owner registers them on done.
   assign done = (cnt_q == CNT_W'(1));
   assign lo   = q_d;
   assign hi   = acc_d;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle add/sub/logic, iterative mul/div, registered
// result with status flags behind valid/ready handshakes.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int  WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] operand1,
   input  logic [WIDTH-1:0] operand2,
   input  logic [2:0]       operation,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             flag_zero,
   output logic             flag_carry,
   output logic             flag_ovf,
   output logic             flag_err
);

   logic [1:0]       state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic             vld_q, vld_d;
   logic             z_q, z_d, c_q, c_d, o_q, o_d, e_q, e_d;

   logic             accept, iter;
   logic [WIDTH:0]   add_s, sub_s;
   logic             md_done;
   logic [WIDTH-1:0] md_lo, md_hi;

   assign in_ready = (state_q == ST_IDLE);
   assign accept   = in_valid && in_ready;
   assign iter     = needs_iter(operation, operand2 != '0);

   alu_seq_muldiv #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_muldiv (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (accept && iter),
      .op_is_div (operation == OP_DIV),
      .op1       (operand1),
      .op2       (operand2),
      .done      (md_done),
      .lo        (md_lo),
      .hi        (md_hi)
   );

   always_comb begin
      add_s   = {1'b0, operand1} + {1'b0, operand2};
      sub_s   = {1'b0, operand1} - {1'b0, operand2};
      state_d = state_q;
      op_d    = op_q;
      res_d   = res_q;
      hi_d    = hi_q;
      vld_d   = vld_q;
      z_d     = z_q;
      c_d     = c_q;
      o_d     = o_q;
      e_d     = e_q;
      case (state_q)
         ST_IDLE: if (accept) begin
            op_d = operation;
            if (iter) begin
               state_d = ST_EXEC;
            end else begin
               state_d = ST_DONE;
               vld_d   = 1'b1;
               hi_d    = '0;
               c_d     = 1'b0;
               o_d     = 1'b0;
               e_d     = 1'b0;
               case (operation)
                  OP_ADD: begin
                     res_d = add_s[WIDTH-1:0];
                     c_d   = add_s[WIDTH];
                     o_d   = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                             (add_s[WIDTH-1] != operand1[WIDTH-1]);
                  end
                  OP_SUB: begin
                     res_d = sub_s[WIDTH-1:0];
                     c_d   = sub_s[WIDTH];
                     o_d   = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                             (sub_s[WIDTH-1] != operand1[WIDTH-1]);
                  end
                  OP_DIV: begin
                     res_d = '1;
                     hi_d  = operand1;
                     e_d   = 1'b1;
                  end
                  OP_AND: res_d = operand1 & operand2;
                  OP_OR:  res_d = operand1 | operand2;
                  OP_XOR: res_d = operand1 ^ operand2;
                  default: begin
                     res_d = '0;
                     e_d   = 1'b1;
                  end
               endcase
               z_d = (res_d == '0);
            end
         end
         ST_EXEC: if (md_done) begin
            state_d = ST_DONE;
            vld_d   = 1'b1;
            res_d   = md_lo;
            hi_d    = md_hi;
            z_d     = (md_lo == '0);
            c_d     = (op_q == OP_MUL) && (md_hi != '0);
            o_d     = 1'b0;
            e_d     = 1'b0;
         end
         ST_DONE: if (out_ready) begin
            // Flags only carry meaning alongside a valid result.
            state_d = ST_IDLE;
            vld_d   = 1'b0;
            z_d     = 1'b0;
            c_d     = 1'b0;
            o_d     = 1'b0;
            e_d     = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         res_q   <= '0;
         hi_q    <= '0;
         vld_q   <= 1'b0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
         o_q     <= 1'b0;
         e_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         res_q   <= res_d;
         hi_q    <= hi_d;
         vld_q   <= vld_d;
         z_q     <= z_d;
         c_q     <= c_d;
         o_q     <= o_d;
         e_q     <= e_d;
      end
   end

   assign out_valid  = vld_q;
   assign result     = res_q;
   assign result_hi  = hi_q;
   assign flag_zero  = z_q;
   assign flag_carry = c_q;
   assign flag_ovf   = o_q;
   assign flag_err   = e_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed and model-driven bench for alu_seq at WIDTH=8.
module tb_alu_seq;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] operand1 = '0;
   logic [W-1:0] operand2 = '0;
   logic [2:0]   operation = '0;
   logic         in_ready, out_valid;
   logic [W-1:0] result, result_hi;
   logic         flag_zero, flag_carry, flag_ovf, flag_err;

   int nchk = 0;
   int nerr = 0;

   alu_seq #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .operand1   (operand1),
      .operand2   (operand2),
      .operation  (operation),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .result_hi  (result_hi),
      .flag_zero  (flag_zero),
      .flag_carry (flag_carry),
      .flag_ovf   (flag_ovf),
      .flag_err   (flag_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] flags();
      return {flag_zero, flag_carry, flag_ovf, flag_err};
   endfunction

   // Present one request for one edge; the block is expected to be idle.
   task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      operation = op;
      operand1  = a;
      operand2  = b;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
   endtask

   task automatic do_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] er, input logic [W-1:0] eh,
                        input logic [3:0] ef, input int elat);
      int  lat;
      bit  busy_ok;
      chk({tag, "_inrdy"}, 32'(in_ready), 32'd1);
      start_op(op, a, b);
      lat = 1;
      busy_ok = 1'b1;
      while (!out_valid && lat < 40) begin
         if (in_ready) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, "_lat"}, 32'(lat), 32'(elat));
      chk({tag, "_res"}, 32'(result), 32'(er));
      chk({tag, "_hi"},  32'(result_hi), 32'(eh));
      chk({tag, "_flg"}, 32'(flags()), 32'(ef));
      if (elat > 1) chk({tag, "_busy"}, 32'(busy_ok), 32'd1);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, "_vldfall"}, 32'(out_valid), 32'd0);
   endtask

   // Reference model built from plain integer arithmetic.
   task automatic model(input logic [2:0] op, input int a, input int b,
                        output logic [W-1:0] r, output logic [W-1:0] h,
                        output logic [3:0] f, output int lat);
      int sa, sb, s, rr, hh;
      bit c, o, e;
      sa = (a >= 128) ? a - 256 : a;
      sb = (b >= 128) ? b - 256 : b;
      rr = 0; hh = 0; c = 0; o = 0; e = 0; lat = 1;
      case (op)
         3'd0: begin s = sa + sb; rr = (a + b) % 256; c = (a + b) > 255; o = (s > 127) || (s < -128); end
         3'd1: begin s = sa - sb; rr = (a - b + 256) % 256; c = a < b; o = (s > 127) || (s < -128); end
         3'd2: begin rr = (a * b) % 256; hh = (a * b) / 256; c = hh != 0; lat = 9; end
         3'd3: begin
            if (b == 0) begin rr = 255; hh = a; e = 1; end
            else begin rr = a / b; hh = a % b; lat = 9; end
         end
         3'd4: rr = a & b;
         3'd5: rr = a | b;
         3'd6: rr = a ^ b;
         default: e = 1;
      endcase
      r = W'(rr);
      h = W'(hh);
      f = {rr == 0, c, o, e};
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] er, eh, ra, rb;
      logic [3:0]   ef;
      logic [2:0]   rop;
      int           elat;

      #12;
      chk("rst_inrdy", 32'(in_ready), 32'd1);
      chk("rst_vld",   32'(out_valid), 32'd0);
      chk("rst_res",   32'(result), 32'd0);
      chk("rst_hi",    32'(result_hi), 32'd0);
      chk("rst_flg",   32'(flags()), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      do_op("add200_100", 3'd0, 8'd200, 8'd100, 8'h2C, 8'h00, 4'b0100, 1);
      do_op("sub80_01",   3'd1, 8'h80,  8'h01,  8'h7F, 8'h00, 4'b0010, 1);
      do_op("mulFF_FF",   3'd2, 8'hFF,  8'hFF,  8'h01, 8'hFE, 4'b0100, 9);
      do_op("div100_7",   3'd3, 8'd100, 8'd7,   8'd14, 8'd2,  4'b0000, 9);
      do_op("div5_0",     3'd3, 8'd5,   8'd0,   8'hFF, 8'h05, 4'b0001, 1);
      do_op("illegal",    3'd7, 8'h5A,  8'hA5,  8'h00, 8'h00, 4'b1001, 1);
      do_op("and_zero",   3'd4, 8'h0F,  8'hF0,  8'h00, 8'h00, 4'b1000, 1);
      do_op("or",         3'd5, 8'h0C,  8'h30,  8'h3C, 8'h00, 4'b0000, 1);
      do_op("add7F_01",   3'd0, 8'h7F,  8'h01,  8'h80, 8'h00, 4'b0010, 1);
      do_op("sub00_01",   3'd1, 8'h00,  8'h01,  8'hFF, 8'h00, 4'b0100, 1);
      do_op("mul0_55",    3'd2, 8'h00,  8'h55,  8'h00, 8'h00, 4'b1000, 9);
      do_op("mul0F_11",   3'd2, 8'h0F,  8'h11,  8'hFF, 8'h00, 4'b0000, 9);
      do_op("div7_9",     3'd3, 8'd7,   8'd9,   8'd0,  8'd7,  4'b1000, 9);
      do_op("divFF_01",   3'd3, 8'hFF,  8'h01,  8'hFF, 8'h00, 4'b0000, 9);

      // Backpressure with a request queued behind the stalled result.
      start_op(3'd6, 8'hF0, 8'hFF);
      operation = 3'd0;
      operand1  = 8'd1;
      operand2  = 8'd2;
      in_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_vld",   32'(out_valid), 32'd1);
         chk("bp_res",   32'(result), 32'h0F);
         chk("bp_inrdy", 32'(in_ready), 32'd0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("bp_idle_inrdy", 32'(in_ready), 32'd1);
      chk("bp_idle_vld",   32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_pend_vld", 32'(out_valid), 32'd1);
      chk("bp_pend_res", 32'(result), 32'd3);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;

      // Asynchronous reset in the middle of a multiply.
      start_op(3'd2, 8'hAB, 8'hCD);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_vld",   32'(out_valid), 32'd0);
      chk("arst_res",   32'(result), 32'd0);
      chk("arst_hi",    32'(result_hi), 32'd0);
      chk("arst_flg",   32'(flags()), 32'd0);
      chk("arst_inrdy", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("arst_novld", 32'(out_valid), 32'd0);
      do_op("add3_4", 3'd0, 8'd3, 8'd4, 8'd7, 8'd0, 4'b0000, 1);

      for (int n = 0; n < 40; n++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = (n % 5 == 0) ? 8'hFF : 8'($urandom_range(0, 255));
         rb  = (n % 7 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
         model(rop, int'(ra), int'(rb), er, eh, ef, elat);
         do_op($sformatf("rnd%0d_op%0d", n, rop), rop, ra, rb, er, eh, ef, elat);
      end

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
